rrf_free_list: RTL and testbench

Retirement register file (RRAT) plus physical-register free list. It sits at the commit end of the ROB and consumes the ROB's in-order dequeue stream (`deq`, `pd_out`, `rd_out`). It keeps the committed architectural-to-physical map and returns each overwritten physical register to a circular free list, which hands out physical registers to the rename unit. It also supplies the committed map and free-list pointer that branch recovery restores from.

---
 rtl/rrf_free_list.sv | 101 ++++++++++
 tb/tb_rrf_free_list.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_free_list.sv
// Purpose : committed arch->phys map (RRAT) plus circular free list of physical registers.
// Latency : commits and allocations update state in 1 cycle; alloc_pd/fl_empty come combinationally from registered state.
// Backpr. : no handshake; alloc_req is ignored while fl_empty=1 or flush=1, and a push into a full list is dropped.
//
// Ports:
//   clk, rst                         single clock, synchronous active-high reset
//   commit, commit_rd, commit_pd     in-order ROB dequeue stream (rd=0 commits are no-ops)
//   alloc_req -> alloc_pd, fl_empty  rename-side pop; alloc_pd shows the current head entry
//   flush, recover_fl_head           mispredict recovery: rewinds the head pointer only
//   fl_head                          head pointer with wrap bit, checkpointed by rename
//   rrat_map                         registered committed map, one PW-bit tag per arch reg
module rrf_free_list #(
    parameter int P_REG_NUM    = 64,
    parameter int ARCH_REG_NUM = 32,
    parameter int FL_DEPTH     = P_REG_NUM - ARCH_REG_NUM,
    localparam int PW          = $clog2(P_REG_NUM),
    localparam int FW          = $clog2(FL_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               commit,
    input  logic [4:0]                         commit_rd,
    input  logic [PW-1:0]                      commit_pd,
    input  logic                               alloc_req,
    output logic [PW-1:0]                      alloc_pd,
    output logic                               fl_empty,
    input  logic                               flush,
    input  logic [FW:0]                        recover_fl_head,
    output logic [FW:0]                        fl_head,
    output logic [ARCH_REG_NUM-1:0][PW-1:0]    rrat_map
);

    localparam logic [FW:0] PTR_ONE = {{FW{1'b0}}, 1'b1};

    logic [PW-1:0] rrat_q [ARCH_REG_NUM];
    logic [PW-1:0] rrat_d [ARCH_REG_NUM];
    logic [PW-1:0] fl_q   [FL_DEPTH];
    logic [PW-1:0] fl_d   [FL_DEPTH];
    logic [FW:0]   head_q, head_d;
    logic [FW:0]   tail_q, tail_d;
    logic          fl_full;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    assign fl_empty = (head_q == tail_q);
    assign fl_full  = (head_q[FW-1:0] == tail_q[FW-1:0]) && (head_q[FW] != tail_q[FW]);
    assign alloc_pd = fl_q[head_q[FW-1:0]];
    assign fl_head  = head_q;

    always_comb begin
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
            rrat_map[i] = rrat_q[i];
        end
    end

    always_comb begin
        rrat_d = rrat_q;
        fl_d   = fl_q;
        head_d = head_q;
        tail_d = tail_q;

        // x0 is hard-wired: a commit to rd=0 touches neither map nor list,
        // so entry 0 keeps its reset tag forever.
        if (commit && (commit_rd != 5'd0)) begin
            rrat_d[commit_rd] = commit_pd;
            // The overwritten tag is recycled. A full list cannot happen with a
            // consistent ROB; if it does, the push is dropped and tail holds.
            if (!fl_full) begin
                fl_d[tail_q[FW-1:0]] = rrat_q[commit_rd];
                tail_d               = tail_q + PTR_ONE;
            end
        end

        // Recovery only rewinds the head: registers committed since the
        // checkpoint were already pushed at the tail and stay there.
        if (flush) begin
            head_d = recover_fl_head;
        end else if (alloc_req && !fl_empty) begin
            head_d = head_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REG_NUM; i++) begin
                rrat_q[i] <= PW'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PW'(ARCH_REG_NUM + i);
            end
            head_q <= '0;
            tail_q <= {1'b1, {FW{1'b0}}};
        end else begin
            rrat_q <= rrat_d;
            fl_q   <= fl_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_rrf_free_list.sv
// Purpose : directed self-checking bench for rrf_free_list with a queue-based free-list model.
// Latency : inputs driven 1 time unit after posedge, outputs sampled before the next posedge.
// Backpr. : none; the bench never pushes into a full list.
module tb_rrf_free_list;

    localparam int PW = 6;
    localparam int FW = 5;
    localparam int NA = 32;
    localparam int FD = 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       commit;
    logic [4:0]                 commit_rd;
    logic [PW-1:0]              commit_pd;
    logic                       alloc_req;
    logic [PW-1:0]              alloc_pd;
    logic                       fl_empty;
    logic                       flush;
    logic [FW:0]                recover_fl_head;
    logic [FW:0]                fl_head;
    logic [NA-1:0][PW-1:0]      rrat_map;

    int checks = 0;
    int errors = 0;

    // Reference model: committed map and free-list contents in pop order.
    int          m_rrat [NA];
    int          m_q [$];
    logic [FW:0] m_head;

    always #5 clk = ~clk;

    rrf_free_list #(
        .P_REG_NUM    (64),
        .ARCH_REG_NUM (32),
        .FL_DEPTH     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .commit          (commit),
        .commit_rd       (commit_rd),
        .commit_pd       (commit_pd),
        .alloc_req       (alloc_req),
        .alloc_pd        (alloc_pd),
        .fl_empty        (fl_empty),
        .flush           (flush),
        .recover_fl_head (recover_fl_head),
        .fl_head         (fl_head),
        .rrat_map        (rrat_map)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit          = 1'b0;
        commit_rd       = 5'd0;
        commit_pd       = '0;
        alloc_req       = 1'b0;
        flush           = 1'b0;
        recover_fl_head = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        checks++; if (alloc_pd !== 6'd32) begin errors++; $display("FAIL reset_alloc_pd got %0d exp 32", alloc_pd); end
        checks++; if (fl_empty !== 1'b0) begin errors++; $display("FAIL reset_fl_empty got %0b exp 0", fl_empty); end
        checks++; if (fl_head !== 6'd0) begin errors++; $display("FAIL reset_fl_head got %0d exp 0", fl_head); end
        checks++; if (rrat_map[5] !== 6'd5) begin errors++; $display("FAIL reset_rrat5 got %0d exp 5", rrat_map[5]); end
        checks++; if (rrat_map[0] !== 6'd0) begin errors++; $display("FAIL reset_rrat0 got %0d exp 0", rrat_map[0]); end
        checks++; if (rrat_map[31] !== 6'd31) begin errors++; $display("FAIL reset_rrat31 got %0d exp 31", rrat_map[31]); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            checks++; if (alloc_pd !== 6'(32 + i)) begin errors++; $display("FAIL drain_alloc_pd[%0d] got %0d exp %0d", i, alloc_pd, 32 + i); end
            step();
        end
        alloc_req = 1'b0;
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b exp 1", fl_empty); end
        checks++; if (fl_head !== 6'b100000) begin errors++; $display("FAIL drain_head got %b exp 100000", fl_head); end
        // Request against an empty list must not move the head.
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        checks++; if (fl_head !== 6'b100000) begin errors++; $display("FAIL drain_extra_head got %b exp 100000", fl_head); end
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL drain_extra_empty got %0b exp 1", fl_empty); end
    endtask

    task automatic test_commit_free();
        commit    = 1'b1;
        commit_rd = 5'd5;
        commit_pd = 6'd40;
        // No bypass: the freed tag is not visible before the edge.
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL commit_nobypass_empty got %0b exp 1", fl_empty); end
        step();
        commit = 1'b0;
        checks++; if (rrat_map[5] !== 6'd40) begin errors++; $display("FAIL commit_rrat5 got %0d exp 40", rrat_map[5]); end
        checks++; if (fl_empty !== 1'b0) begin errors++; $display("FAIL commit_empty got %0b exp 0", fl_empty); end
        checks++; if (alloc_pd !== 6'd5) begin errors++; $display("FAIL commit_alloc_pd got %0d exp 5", alloc_pd); end
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL commit_pop_empty got %0b exp 1", fl_empty); end
        checks++; if (fl_head !== 6'b100001) begin errors++; $display("FAIL commit_pop_head got %b exp 100001", fl_head); end
    endtask

    task automatic test_x0();
        commit    = 1'b1;
        commit_rd = 5'd0;
        commit_pd = 6'd50;
        step();
        commit = 1'b0;
        checks++; if (rrat_map[0] !== 6'd0) begin errors++; $display("FAIL x0_rrat0 got %0d exp 0", rrat_map[0]); end
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL x0_tail_moved empty got %0b exp 1", fl_empty); end
        checks++; if (fl_head !== 6'b100001) begin errors++; $display("FAIL x0_head got %b exp 100001", fl_head); end
    endtask

    task automatic test_flush();
        // Reset mid-operation with every other control asserted: all ignored.
        rst             = 1'b1;
        commit          = 1'b1;
        commit_rd       = 5'd7;
        commit_pd       = 6'd60;
        alloc_req       = 1'b1;
        flush           = 1'b1;
        recover_fl_head = 6'd9;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++; if (fl_head !== 6'd0) begin errors++; $display("FAIL rst_mid_head got %0d exp 0", fl_head); end
        checks++; if (rrat_map[7] !== 6'd7) begin errors++; $display("FAIL rst_mid_rrat7 got %0d exp 7", rrat_map[7]); end
        checks++; if (rrat_map[5] !== 6'd5) begin errors++; $display("FAIL rst_mid_rrat5 got %0d exp 5", rrat_map[5]); end
        checks++; if (alloc_pd !== 6'd32) begin errors++; $display("FAIL rst_mid_alloc_pd got %0d exp 32", alloc_pd); end
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1'b1;
            checks++; if (alloc_pd !== 6'(32 + i)) begin errors++; $display("FAIL flush_pre_alloc[%0d] got %0d exp %0d", i, alloc_pd, 32 + i); end
            step();
        end
        checks++; if (fl_head !== 6'd3) begin errors++; $display("FAIL flush_pre_head got %0d exp 3", fl_head); end
        alloc_req       = 1'b1;
        flush           = 1'b1;
        recover_fl_head = 6'd1;
        step();
        idle_inputs();
        checks++; if (fl_head !== 6'd1) begin errors++; $display("FAIL flush_head got %0d exp 1", fl_head); end
        checks++; if (alloc_pd !== 6'd33) begin errors++; $display("FAIL flush_alloc_pd got %0d exp 33", alloc_pd); end
    endtask

    task automatic test_back_to_back();
        int rd;
        int pd;
        // State after test_flush: identity map, head=1, tail=32, entries 33..63.
        for (int i = 0; i < NA; i++) m_rrat[i] = i;
        m_q.delete();
        for (int v = 33; v < 64; v++) m_q.push_back(v);
        m_head = 6'd1;

        // Commit and allocate together; head crosses index 31 and the tail
        // crosses 63, so both wrap bits toggle.
        for (int k = 0; k < 40; k++) begin
            rd = (k % 31) + 1;
            pd = m_q[0];
            commit    = 1'b1;
            commit_rd = 5'(rd);
            commit_pd = 6'(pd);
            alloc_req = 1'b1;
            assert (m_q.size() < FD) else $error("push into full list at k=%0d", k);
            checks++; if (alloc_pd !== 6'(m_q[0])) begin errors++; $display("FAIL b2b_alloc_pd[%0d] got %0d exp %0d", k, alloc_pd, m_q[0]); end
            checks++; if (fl_head !== m_head) begin errors++; $display("FAIL b2b_head[%0d] got %b exp %b", k, fl_head, m_head); end
            m_q.push_back(m_rrat[rd]);
            void'(m_q.pop_front());
            m_rrat[rd] = pd;
            m_head     = m_head + 6'd1;
            step();
            checks++; if (rrat_map[rd] !== 6'(pd)) begin errors++; $display("FAIL b2b_rrat[%0d] got %0d exp %0d", rd, rrat_map[rd], pd); end
            checks++; if (fl_empty !== 1'b0) begin errors++; $display("FAIL b2b_empty[%0d] got %0b exp 0", k, fl_empty); end
        end
        idle_inputs();

        // Drain the remaining 31 entries in push order.
        for (int j = 0; j < 31; j++) begin
            checks++; if (fl_empty !== 1'b0) begin errors++; $display("FAIL b2b_drain_empty[%0d] got %0b exp 0", j, fl_empty); end
            checks++; if (alloc_pd !== 6'(m_q[0])) begin errors++; $display("FAIL b2b_drain_pd[%0d] got %0d exp %0d", j, alloc_pd, m_q[0]); end
            void'(m_q.pop_front());
            m_head    = m_head + 6'd1;
            alloc_req = 1'b1;
            step();
        end
        alloc_req = 1'b0;
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL b2b_drained_empty got %0b exp 1", fl_empty); end
        checks++; if (fl_head !== m_head) begin errors++; $display("FAIL b2b_drained_head got %b exp %b", fl_head, m_head); end

        // Refill to exactly full with commits only; full must not read as empty.
        for (int j = 0; j < 32; j++) begin
            rd = (j % 31) + 1;
            pd = j + 2;
            commit    = 1'b1;
            commit_rd = 5'(rd);
            commit_pd = 6'(pd);
            assert (m_q.size() < FD) else $error("push into full list at j=%0d", j);
            m_q.push_back(m_rrat[rd]);
            m_rrat[rd] = pd;
            step();
            checks++; if (fl_empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %0b exp 0", j, fl_empty); end
        end
        idle_inputs();
        for (int j = 0; j < 32; j++) begin
            checks++; if (alloc_pd !== 6'(m_q[0])) begin errors++; $display("FAIL fill_drain_pd[%0d] got %0d exp %0d", j, alloc_pd, m_q[0]); end
            void'(m_q.pop_front());
            alloc_req = 1'b1;
            step();
        end
        alloc_req = 1'b0;
        checks++; if (fl_empty !== 1'b1) begin errors++; $display("FAIL fill_drained_empty got %0b exp 1", fl_empty); end
        for (int i = 0; i < NA; i++) begin
            checks++; if (rrat_map[i] !== 6'(m_rrat[i])) begin errors++; $display("FAIL final_rrat[%0d] got %0d exp %0d", i, rrat_map[i], m_rrat[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_drain();
        test_commit_free();
        test_x0();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
